// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: the port owner encoding
// and a helper for sizing the saturating counters.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment, and
// the count holds once it reaches MAX.
module sat_counter #(
    parameter int W   = 3,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_max
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max = (count_q == W'(MAX));
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the CPU data port and a debug/DMA
// master. The CPU has priority; starvation and locked-burst limits keep debug moving.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic [DW/8-1:0] cpu_we,
    output logic            cpu_stall,
    output logic            cpu_gnt,
    input  logic            dbg_req,
    input  logic            dbg_lock,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [DW-1:0]   dbg_wdata,
    input  logic [DW/8-1:0] dbg_we,
    output logic            dbg_gnt,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   daddr,
    output logic [DW-1:0]   dwdata,
    output logic [DW/8-1:0] dwe,
    input  logic [DW-1:0]   drdata
);

    localparam int WAIT_W  = cnt_width(MAX_WAIT);
    localparam int BURST_W = cnt_width(MAX_BURST);

    owner_e owner_q;
    owner_e owner_d;

    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               wait_at_max;
    logic               burst_at_max;
    logic               cpu_gnt_c;
    logic               dbg_gnt_c;
    logic               cnt_unused;

    // The raw counts are kept visible for debug; arbitration only needs at_max.
    assign cnt_unused = ^{wait_cnt, burst_cnt};

    always_comb begin
        cpu_gnt_c = 1'b0;
        dbg_gnt_c = 1'b0;
        owner_d   = OWN_NONE;
        if (!reset) begin
            if (owner_q == OWN_DBG && dbg_req && dbg_lock && !burst_at_max) begin
                dbg_gnt_c = 1'b1;
            end else if (dbg_req && (!cpu_req || wait_at_max)) begin
                dbg_gnt_c = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt_c = 1'b1;
            end
        end
        if (dbg_gnt_c) begin
            owner_d = OWN_DBG;
        end else if (cpu_gnt_c) begin
            owner_d = OWN_CPU;
        end
    end

    // With no grant the address/data follow the CPU so dmem sees a stable address.
    always_comb begin
        daddr  = cpu_addr;
        dwdata = cpu_wdata;
        dwe    = '0;
        if (dbg_gnt_c) begin
            daddr  = dbg_addr;
            dwdata = dbg_wdata;
            dwe    = dbg_we;
        end else if (cpu_gnt_c) begin
            dwe = cpu_we;
        end
    end

    assign cpu_gnt   = cpu_gnt_c;
    assign dbg_gnt   = dbg_gnt_c;
    assign cpu_stall = !reset && cpu_req && !cpu_gnt_c;
    assign rdata     = drdata;

    sat_counter #(
        .W   (WAIT_W),
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (dbg_req && !dbg_gnt_c),
        .clr    (dbg_gnt_c || !dbg_req),
        .count  (wait_cnt),
        .at_max (wait_at_max)
    );

    // Burst length only advances while the CPU is actually being held off.
    sat_counter #(
        .W   (BURST_W),
        .MAX (MAX_BURST)
    ) u_burst_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (dbg_gnt_c && cpu_req),
        .clr    (!dbg_gnt_c),
        .count  (burst_cnt),
        .at_max (burst_at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small byte-lane memory model
// attached to the dmem side.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, dbg_req, dbg_lock;
    logic [AW-1:0] cpu_addr, dbg_addr, daddr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, dwdata, rdata, drdata;
    logic [3:0]    cpu_we, dbg_we, dwe;
    logic          cpu_stall, cpu_gnt, dbg_gnt;

    logic          ld_en;
    logic [5:0]    ld_idx;
    logic [31:0]   ld_val;
    logic [31:0]   mem [0:63];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(4), .MAX_BURST(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .cpu_stall(cpu_stall), .cpu_gnt(cpu_gnt),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_we(dbg_we), .dbg_gnt(dbg_gnt),
        .rdata(rdata), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
    );

    assign drdata = mem[daddr[7:2]];

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_val;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (dwe[b]) mem[daddr[7:2]][8*b +: 8] <= dwdata[8*b +: 8];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic cr, input logic dr, input logic dl);
        @(negedge clk);
        cpu_req  = cr;
        dbg_req  = dr;
        dbg_lock = dl;
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic exp_cpu, input logic exp_dbg);
        chk({tag, ".cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, exp_cpu});
        chk({tag, ".dbg_gnt"}, {31'd0, dbg_gnt}, {31'd0, exp_dbg});
        chk({tag, ".stall"}, {31'd0, cpu_stall}, {31'd0, cpu_req && !exp_cpu});
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 0; dbg_req = 0; dbg_lock = 0;
        cpu_addr = 0; cpu_wdata = 0; cpu_we = 0;
        dbg_addr = 0; dbg_wdata = 0; dbg_we = 0;
        ld_en = 0; ld_idx = 0; ld_val = 0;

        // Preload memory while reset holds the arbiter idle.
        @(negedge clk); ld_en = 1; ld_idx = 6'd8;  ld_val = 32'h1234_5678;
        @(negedge clk); ld_idx = 6'd16; ld_val = 32'h1122_3344;
        @(negedge clk); ld_idx = 6'd4;  ld_val = 32'h0000_0000;
        @(negedge clk); ld_en = 0;

        // Reset state with both masters requesting and write enables set.
        cpu_we = 4'hF; dbg_we = 4'hF;
        step(1, 1, 1);
        chk("rst.cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("rst.dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("rst.dwe", {28'd0, dwe}, 32'd0);
        chk("rst.stall", {31'd0, cpu_stall}, 32'd0);
        step(0, 0, 0);
        reset = 1'b0;
        dbg_we = 4'h0;

        // Test 1: CPU store alone.
        cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF; cpu_we = 4'hF;
        step(1, 0, 0);
        chk_gnt("t1", 1'b1, 1'b0);
        chk("t1.dwe", {28'd0, dwe}, 32'h0000_000F);
        chk("t1.daddr", daddr, 32'h10);
        step(0, 0, 0);
        chk("t1.mem4", mem[4], 32'hDEAD_BEEF);
        chk("idle.dwe", {28'd0, dwe}, 32'd0);
        chk_gnt("idle", 1'b0, 1'b0);

        // Test 2: debug read alone.
        dbg_addr = 32'h20; dbg_we = 4'h0;
        step(0, 1, 0);
        chk_gnt("t2", 1'b0, 1'b1);
        chk("t2.daddr", daddr, 32'h20);
        chk("t2.rdata", rdata, 32'h1234_5678);

        // Test 6: debug single-byte write; CPU enables must not leak through.
        dbg_addr = 32'h40; dbg_wdata = 32'hAABB_CCDD; dbg_we = 4'b0010;
        cpu_addr = 32'h40; cpu_wdata = 32'hFFFF_FFFF; cpu_we = 4'hF;
        step(0, 1, 0);
        chk_gnt("t6", 1'b0, 1'b1);
        chk("t6.dwe", {28'd0, dwe}, 32'h0000_0002);
        chk("t6.dwdata", dwdata, 32'hAABB_CCDD);
        step(0, 0, 0);
        chk("t6.mem16", mem[16], 32'h1122_CC44);

        // Test 3: continuous contention without lock, 4 CPU then 1 debug.
        cpu_we = 4'h0; dbg_we = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0);
            chk_gnt($sformatf("t3.c%0d", i), (i % 5) != 4, (i % 5) == 4);
        end
        step(0, 0, 0);

        // Test 4: contention with lock, forced grant then 8-grant burst, then CPU.
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 1);
            chk_gnt($sformatf("t4.c%0d", i),
                    !((i >= 4 && i <= 11) || i == 16),
                    (i >= 4 && i <= 11) || i == 16);
        end
        step(0, 0, 0);

        // Test 5: reset mid-burst once burst_cnt has reached 3.
        cpu_we = 4'hF; dbg_we = 4'hF;
        cpu_addr = 32'h0; dbg_addr = 32'h4;
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 1);
            chk_gnt($sformatf("t5.pre%0d", i), i < 4, i >= 4);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5.rst.cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("t5.rst.dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        chk("t5.rst.dwe", {28'd0, dwe}, 32'd0);
        chk("t5.rst.stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_gnt("t5.post0", 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) begin
            step(1, 1, 1);
            chk_gnt($sformatf("t5.post%0d", i), i < 4, i >= 4);
        end

        // Lock dropped mid-burst hands the port straight back to the CPU.
        step(1, 1, 1);
        chk_gnt("lockdrop.held", 1'b0, 1'b1);
        step(1, 1, 0);
        chk_gnt("lockdrop.cpu", 1'b1, 1'b0);
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
